// File: rtl/acc_monitor.sv
// acc_monitor: periodic accelerometer fetch scheduler with timeout, sample capture and consecutive-hit alarm
module acc_monitor #(
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 4096,
  parameter int HITS    = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [23:0] threshold,
  input  logic        sensor_ready,
  output logic        fetch,
  input  logic        arrived,
  input  logic [23:0] acc,
  output logic [23:0] sample,
  output logic        sample_valid,
  output logic [7:0]  streak,
  output logic        alarm,
  output logic        timeout_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, BUSY} state_t;
  localparam logic [20:0] I_LAST = 21'(PERIOD - 1);
  localparam logic [20:0] T_LAST = 21'(TIMEOUT - 1);
  localparam logic [7:0]  HITS_L = 8'(HITS);
  state_t state, state_nx;
  logic [20:0] icnt, tcnt;
  logic [7:0] streak_nx;
  logic go, got, tout;
  assign busy = state == BUSY;
  always_comb begin
    go        = state == WAIT && enable && icnt == I_LAST && sensor_ready;
    got       = state == BUSY && arrived;
    tout      = state == BUSY && !arrived && tcnt == T_LAST;
    streak_nx = acc > threshold ? (streak == 8'hff ? streak : streak + 8'd1) : 8'd0;
    state_nx  = state;
    case (state)
      IDLE:    state_nx = enable ? WAIT : IDLE;
      WAIT:    state_nx = !enable ? IDLE : go ? BUSY : WAIT;
      BUSY:    state_nx = got ? (enable ? WAIT : IDLE) : tout ? IDLE : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      icnt         <= '0;
      tcnt         <= '0;
      fetch        <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      streak       <= '0;
      alarm        <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nx;
      fetch        <= go;
      sample_valid <= got;
      icnt         <= state == IDLE ? I_LAST : go ? '0 : icnt == I_LAST ? icnt : icnt + 21'd1;
      tcnt         <= go ? '0 : state == BUSY ? tcnt + 21'd1 : tcnt;
      if (got) begin
        sample <= acc;
        streak <= streak_nx;
        if (streak_nx >= HITS_L) alarm <= 1'b1;
      end
      if (tout) begin
        timeout_err <= 1'b1;
        streak      <= '0;
      end
      if (clear) begin
        alarm       <= 1'b0;
        streak      <= '0;
        timeout_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_acc_monitor.sv
// tb_acc_monitor: randomized transaction-level check of acc_monitor against a behavioural model
module tb_acc_monitor;
  localparam int P = 16, T = 64, H = 3;
  logic Clock = 0, Reset = 1, enable = 0, clear = 0, sensor_ready = 1, arrived = 0;
  logic [23:0] threshold = 0, acc = 0;
  logic fetch, sample_valid, alarm, timeout_err, busy;
  logic [23:0] sample;
  logic [7:0] streak;
  int n_chk = 0, n_fail = 0, cyc = 0, tf = 0;
  logic [23:0] m_sample = 0;
  int m_streak = 0;
  bit m_alarm = 0;
  logic [23:0] seq [8] = '{300, 300, 150, 300, 300, 300, 0, 0};

  acc_monitor #(.PERIOD(P), .TIMEOUT(T), .HITS(H)) dut (
    .Clock(Clock), .Reset(Reset), .enable(enable), .clear(clear), .threshold(threshold),
    .sensor_ready(sensor_ready), .fetch(fetch), .arrived(arrived), .acc(acc), .sample(sample),
    .sample_valid(sample_valid), .streak(streak), .alarm(alarm), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input logic [23:0] a, input logic [23:0] t, input bit clr);
    m_sample = a;
    m_streak = a > t ? (m_streak == 255 ? 255 : m_streak + 1) : 0;
    if (m_streak >= H) m_alarm = 1;
    if (clr) begin
      m_streak = 0;
      m_alarm  = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fetch"}, fetch, 0);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_streak"}, streak, 0);
    check({tag, "_alarm"}, alarm, 0);
    check({tag, "_tmo"}, timeout_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_fetch(input int budget, input int restore_at);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clock);
      if (fetch) seen = 1;
      else if (cyc == restore_at) sensor_ready = 1;
    end
    if (!seen) check("fetch_seen", 0, 1);
    tf = cyc;
  endtask

  task automatic txn(input logic [23:0] a, input logic [23:0] t, input int d, input bit clr, input int r);
    int c = tf;
    int gap;
    repeat (d) @(negedge Clock);
    check("busy_hi", busy, 1);
    arrived = 1; acc = a; threshold = t; clear = clr;
    @(negedge Clock);
    arrived = 0; clear = 0; acc = 24'($urandom);
    model(a, t, clr);
    check("sample", sample, m_sample);
    check("sample_valid", sample_valid, 1);
    check("streak", streak, m_streak);
    check("alarm", alarm, m_alarm);
    check("busy_lo", busy, 0);
    gap = (P > d + 2 ? P : d + 2) + r;
    if (r > 0) sensor_ready = 0;
    wait_fetch(gap + 10, c + gap - 1);
    check("spacing", tf - c, gap);
  endtask

  initial begin
    int e, c, nf;
    logic [23:0] thr, a;
    repeat (2) @(negedge Clock);
    check_zero("reset");
    Reset = 0;
    @(negedge Clock);
    enable = 1;
    e = cyc;
    wait_fetch(10, -1);
    check("first_fetch_lat", tf - e, 2);
    repeat (4) txn(100, 200, 5, 0, 0);
    foreach (seq[i]) txn(seq[i], 200, 5, 0, 0);
    txn(300, 200, 5, 0, 0);
    txn(300, 200, 5, 0, 0);
    txn(300, 200, 5, 1, 0);
    txn(300, 200, 5, 0, 0);
    txn(100, 200, 5, 0, 10);
    repeat (40) begin
      thr = 24'($urandom_range(8000000, 1000));
      a = $urandom_range(1, 0) == 1 ? thr + 24'($urandom_range(1000, 1)) : thr - 24'($urandom_range(999, 0));
      txn(a, thr, $urandom_range(20, 1), $urandom_range(5, 0) == 0, $urandom_range(3, 0) == 0 ? $urandom_range(8, 1) : 0);
    end
    txn(500, 200, 3, 0, 0);
    c = tf;
    repeat (T - 1) @(negedge Clock);
    check("tmo_early", timeout_err, 0);
    check("tmo_busy", busy, 1);
    @(negedge Clock);
    enable = 0;
    m_streak = 0;
    check("tmo_at", cyc - c, T);
    check("tmo_set", timeout_err, 1);
    check("tmo_idle", busy, 0);
    check("tmo_streak", streak, 0);
    repeat (5) @(negedge Clock);
    arrived = 1; acc = 777;
    @(negedge Clock);
    arrived = 0;
    check("late_sample", sample, m_sample);
    check("late_valid", sample_valid, 0);
    check("late_streak", streak, 0);
    clear = 1;
    @(negedge Clock);
    clear = 0;
    m_alarm = 0;
    check("clr_tmo", timeout_err, 0);
    check("clr_alarm", alarm, 0);
    enable = 1;
    wait_fetch(10, -1);
    repeat (2) @(negedge Clock);
    enable = 0;
    repeat (2) @(negedge Clock);
    check("drop_busy", busy, 1);
    arrived = 1; acc = 400; threshold = 200;
    @(negedge Clock);
    arrived = 0;
    model(400, 200, 0);
    check("drop_sample", sample, m_sample);
    check("drop_valid", sample_valid, 1);
    check("drop_streak", streak, m_streak);
    check("drop_busy_lo", busy, 0);
    nf = 0;
    repeat (40) begin
      @(negedge Clock);
      if (fetch) nf++;
    end
    check("drop_no_fetch", nf, 0);
    enable = 1;
    wait_fetch(10, -1);
    repeat (3) txn(300, 200, 4, 0, 0);
    check("pre_reset_alarm", alarm, 1);
    repeat (2) @(negedge Clock);
    Reset = 1; enable = 0;
    @(negedge Clock);
    Reset = 0;
    check_zero("mid_reset");
    @(negedge Clock);
    arrived = 1; acc = 999;
    @(negedge Clock);
    arrived = 0;
    check("rst_late_sample", sample, 0);
    check("rst_late_valid", sample_valid, 0);
    check("rst_late_streak", streak, 0);
    check("rst_late_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_monitor.md
# acc_monitor

Sampling scheduler and motion detector that sequences the accelerometer reader block in the alarm system. Issues periodic `fetch` pulses, waits for the sensor's `arrived` strobe with a timeout, and latches the 24-bit sum-of-squares magnitude. Raises a sticky `alarm` after a programmable number of consecutive samples exceed a threshold.

## Interface
- `PERIOD`, 1000 — clock cycles from one `fetch` issue to the next; legal range 2..2^20.
- `TIMEOUT`, 4096 — maximum cycles in BUSY waiting for `arrived`; legal range 2..2^20.
- `HITS`, 3 — consecutive over-threshold samples required to set `alarm`; legal range 1..255.

- `Clock`  in  1  sole clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; enables periodic sampling.
- `clear`  in  1  one-cycle pulse; clears `alarm`, `streak` and `timeout_err`.
- `threshold`  in  24  magnitude limit; sampled at the `arrived` edge.
- `sensor_ready`  in  1  accelerometer idle and configured.
- `fetch`  out  1  one-cycle request pulse to the accelerometer.
- `arrived`  in  1  one-cycle strobe; `acc` valid in the same cycle.
- `acc`  in  24  sum of squares of X/Y/Z.
- `sample`  out  24  last captured magnitude.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `streak`  out  8  current consecutive over-threshold count, saturating at 255.
- `alarm`  out  1  sticky detection flag.
- `timeout_err`  out  1  sticky flag; a transaction exceeded `TIMEOUT`.
- `busy`  out  1  high while in BUSY.

## Operation
- Reset values: state IDLE; `fetch`=0, `sample`=0, `sample_valid`=0, `streak`=0, `alarm`=0, `timeout_err`=0, `busy`=0; interval and timeout counters 0.

### States
- **IDLE**
  - Go to WAIT when `enable`=1.
  - On entry, the interval counter loads `PERIOD-1`, so the first fetch goes out as soon as `sensor_ready`=1.
- **WAIT**
  - Interval counter increments, saturating at `PERIOD-1`.
  - When counter = `PERIOD-1` and `sensor_ready`=1: drive `fetch`<=1, reset both counters to 0, go to BUSY.
  - If `sensor_ready`=0 at that point, stay in WAIT with the counter held. The period stretches; no fetch is dropped or queued.
  - `enable`=0 → IDLE immediately.
- **BUSY**
  - `fetch`<=0; `busy`=1. Interval counter keeps counting; timeout counter increments.
  - On `arrived`=1:
    - `sample`<=`acc`; `sample_valid`<=1.
    - If `acc` > `threshold` (unsigned, strict): `streak`<=`streak`+1, saturating at 255. Otherwise `streak`<=0.
    - If the new streak ≥ `HITS`: `alarm`<=1.
    - Next state is WAIT if `enable`=1, else IDLE.
  - On timeout counter = `TIMEOUT-1` with no `arrived`: `timeout_err`<=1, `streak`<=0, go to IDLE. No sample is produced.
  - `enable` falling during BUSY does not abort; the transaction completes or times out.

### Rules
- `arrived` outside BUSY is ignored: no sample, no streak change.
- `clear` coinciding with an alarm-setting `arrived`: `clear` wins. `alarm`=0 and `streak`=0 afterwards; `sample` and `sample_valid` still update.
- `clear` does not affect state, counters or `sample`.
- `alarm` stays set until `clear` or `Reset`, even when later samples fall below `threshold`.
- `Reset` mid-BUSY returns to IDLE with all outputs at reset values. The accelerometer transaction is abandoned; a later `arrived` is ignored per the rule above.

## Timing
- `fetch` is exactly one cycle wide, asserted in the first cycle of BUSY (registered in the WAIT→BUSY edge).
- Fetch-to-fetch spacing is exactly `PERIOD` cycles when `sensor_ready` is high and the transaction finishes within `PERIOD`. Otherwise spacing = max(`PERIOD`, transaction length + 1, next `sensor_ready`).
- `arrived` in cycle n → `sample`, `sample_valid`, `streak`, `alarm` visible in cycle n+1; `busy` low in n+1.
- Timeout: `timeout_err` visible `TIMEOUT` cycles after the first BUSY cycle.
- `enable` rising in IDLE → first `fetch` visible no earlier than 2 cycles later.

## Test plan
- **Basic periodic sampling.** `PERIOD`=16, `sensor_ready`=1, model answers `arrived` 5 cycles after `fetch` with `acc`=100, `threshold`=200. Required: `fetch` pulses every 16 cycles; `sample`=100 and `sample_valid` one cycle after each `arrived`; `streak` stays 0; `alarm`=0.
- **Alarm on consecutive hits.** `HITS`=3; sequence `acc`=300, 300, 150, 300, 300, 300 with `threshold`=200. Required: `streak` 1, 2, 0, 1, 2, 3; `alarm` rises one cycle after the 6th `arrived` and remains 1 while later samples = 0.
- **Timeout.** `TIMEOUT`=64, no `arrived`. Required: `timeout_err`=1 at 64 cycles after `fetch`, state IDLE, `streak`=0. A late `arrived` at +70 leaves `sample` unchanged.
- **Slow sensor and enable drop.** `sensor_ready`=0 at the fetch point for 10 extra cycles → `fetch` delayed by exactly 10 cycles. Then drop `enable` mid-BUSY: `arrived` still captured, then IDLE with no further `fetch`.
- **Clear collision.** `clear` pulsed in the same cycle as the 3rd over-threshold `arrived` → `alarm`=0, `streak`=0, `sample` updated. The next over-threshold sample gives `streak`=1.
- **Reset mid-transaction.** Assert `Reset` for 1 cycle during BUSY → all outputs at reset values next cycle; `arrived` 2 cycles later ignored.
